sample_capture_writer: RTL

- Upstream feeder for the correlator's 1024x32 on-chip sample memory.
- Accepts a stream of 16-bit ADC samples and packs two samples per 32-bit word.
- Writes each packed word through the memory's single-port write interface (address, byteenable, chipselect, write, writedata, clken).
- A capture of a programmed number of samples is armed by a start pulse; completion is signalled by a done pulse so the correlator can begin reading.

---
 rtl/korelator_pkg.sv | 31 +++
 rtl/sample_pair_packer.sv | 72 +++++++
 rtl/sample_capture_writer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/korelator_pkg.sv
// korelator_pkg: shared types and constants for the correlator sample-capture path.
//
// Contents:
//   capture_state_t  - capture FSM states (IDLE, CAPTURE, FLUSH, DONE)
//   MEM_DEPTH        - sample memory depth in 32-bit words
//   MEM_ADDR_W       - sample memory word-address width
//   SAMPLE_W         - ADC sample width (two samples fill one memory word)
//   MAX_SAMPLES      - largest capture that fits the memory
//   LEN_W            - width of the programmed capture length
//   clamp_length()   - limits a requested length to the memory capacity
package korelator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } capture_state_t;

  localparam int MEM_DEPTH   = 1024;
  localparam int MEM_ADDR_W  = 10;
  localparam int SAMPLE_W    = 16;
  localparam int MAX_SAMPLES = 2 * MEM_DEPTH;
  localparam int LEN_W       = 12;

  function automatic logic [LEN_W-1:0] clamp_length(input logic [LEN_W-1:0] len,
                                                    input logic [LEN_W-1:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/sample_pair_packer.sv
// sample_pair_packer: pairs consecutive samples into one memory word.
//
// Holds the half flag (a first sample is waiting) and the low-sample register,
// and presents the word/byte-enable the top level should write this cycle:
//   accept with a sample waiting -> {sample_i, low}, be 4'b1111 (full word)
//   accept with nothing waiting  -> {0, sample_i},   be 4'b0011 (odd tail)
//   no accept                    -> {0, low},        be 4'b0011 (pending flush)
// The top level decides whether the presented word is actually written.
//
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   clear_i        drop any waiting sample (start of a new capture)
//   accept_i       a sample is consumed this cycle
//   sample_i       sample value
//   half_o         a first sample is waiting in the low register
//   word_o, be_o   candidate memory word and byte enables
module sample_pair_packer
  import korelator_pkg::*;
#(
  parameter int SW = SAMPLE_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear_i,
  input  logic            accept_i,
  input  logic [SW-1:0]   sample_i,
  output logic            half_o,
  output logic [2*SW-1:0] word_o,
  output logic [3:0]      be_o
);

  logic          half_q, half_d;
  logic [SW-1:0] low_q, low_d;

  always_comb begin
    half_d = half_q;
    low_d  = low_q;
    if (clear_i) begin
      half_d = 1'b0;
    end else if (accept_i) begin
      half_d = ~half_q;
      if (!half_q) begin
        low_d = sample_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_q <= 1'b0;
      low_q  <= '0;
    end else begin
      half_q <= half_d;
      low_q  <= low_d;
    end
  end

  always_comb begin
    word_o = {{SW{1'b0}}, low_q};
    be_o   = 4'b0011;
    if (accept_i && half_q) begin
      word_o = {sample_i, low_q};
      be_o   = 4'b1111;
    end else if (accept_i) begin
      word_o = {{SW{1'b0}}, sample_i};
      be_o   = 4'b0011;
    end
  end

  assign half_o = half_q;

endmodule

// File: rtl/sample_capture_writer.sv
// sample_capture_writer: captures a programmed number of 16-bit ADC samples,
// packs them two per 32-bit word and writes them into the correlator's
// single-port sample memory starting at word address 0.
//
// Optional build macro: CAPTURE_RING_MODE_EN
//   Adds input ring and output wrapped. A ring capture ignores length, wraps
//   the word pointer DEPTH-1 -> 0 and runs until abort, after which a waiting
//   odd sample is flushed (FLUSH state) and done is pulsed.
//
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   start, length       arm a capture of length samples (clamped to 2*DEPTH)
//   abort               stop the current capture
//   ring / wrapped      ring-mode request / pointer has wrapped (macro only)
//   s_valid, s_data     sample stream in; s_ready high while capturing
//   mem_*               memory write port (chipselect mirrors write)
//   busy, done          capture in progress / one-cycle completion pulse
//   words_written       words written by the current or last capture
// All outputs are registered.
module sample_capture_writer
  import korelator_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DEPTH    = MEM_DEPTH,
  parameter int SAMPLE_W = korelator_pkg::SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      length,
  input  logic                  abort,
`ifdef CAPTURE_RING_MODE_EN
  input  logic                  ring,
  output logic                  wrapped,
`endif
  input  logic                  s_valid,
  input  logic [SAMPLE_W-1:0]   s_data,
  output logic                  s_ready,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [3:0]            mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [2*SAMPLE_W-1:0] mem_writedata,
  output logic                  mem_clken,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       words_written
);

  localparam int                MAX_LEN   = 2 * DEPTH;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  capture_state_t        state_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      count_q;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic [ADDR_W:0]       words_q;
  logic                  s_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  write_q;
  logic                  clken_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [3:0]            be_q;
  logic [2*SAMPLE_W-1:0] wdata_q;

  logic                  start_ok;
  logic                  accept;
  logic                  last_sample;
  logic                  ring_act;
  logic                  wrap_hit;

  logic                  pk_half;
  logic [2*SAMPLE_W-1:0] pk_word;
  logic [3:0]            pk_be;

`ifdef CAPTURE_RING_MODE_EN
  logic ring_q;
  logic wrapped_q;
  assign ring_act = ring_q;
  assign wrapped  = wrapped_q;
`else
  assign ring_act = 1'b0;
`endif

  assign start_ok    = (state_q == IDLE) && start && (length != '0);
  assign accept      = (state_q == CAPTURE) && s_ready_q && s_valid;
  // A ring capture has no length limit; it only ends on abort.
  assign last_sample = !ring_act && ((count_q + LEN_W'(1)) == len_q);
  assign ptr_d       = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
  assign wrap_hit    = ring_act && (ptr_q == LAST_ADDR);

  // Abort wins over a sample accepted in the same cycle, so the packer never
  // sees that sample.
  sample_pair_packer #(
    .SW(SAMPLE_W)
  ) u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (start_ok),
    .accept_i(accept && !abort),
    .sample_i(s_data),
    .half_o  (pk_half),
    .word_o  (pk_word),
    .be_o    (pk_be)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      count_q   <= '0;
      ptr_q     <= '0;
      words_q   <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      write_q   <= 1'b0;
      clken_q   <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
`ifdef CAPTURE_RING_MODE_EN
      ring_q    <= 1'b0;
      wrapped_q <= 1'b0;
`endif
    end else begin
      clken_q <= 1'b1;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q   <= CAPTURE;
            len_q     <= clamp_length(length, LEN_W'(MAX_LEN));
            count_q   <= '0;
            ptr_q     <= '0;
            words_q   <= '0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
`ifdef CAPTURE_RING_MODE_EN
            ring_q    <= ring;
            wrapped_q <= 1'b0;
`endif
          end
        end

        CAPTURE: begin
          if (abort) begin
            // A write issued on the previous edge is already on the bus;
            // a waiting half-word is discarded unless ring mode flushes it.
            s_ready_q <= 1'b0;
`ifdef CAPTURE_RING_MODE_EN
            if (ring_act) begin
              state_q <= FLUSH;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
`else
            state_q <= IDLE;
            busy_q  <= 1'b0;
`endif
          end else if (accept) begin
            count_q <= count_q + LEN_W'(1);
            // Second sample of a pair, or an odd final sample (tail word).
            if (pk_half || last_sample) begin
              write_q <= 1'b1;
              addr_q  <= ptr_q;
              be_q    <= pk_be;
              wdata_q <= pk_word;
              ptr_q   <= ptr_d;
              words_q <= words_q + 1'b1;
`ifdef CAPTURE_RING_MODE_EN
              if (wrap_hit) wrapped_q <= 1'b1;
`endif
            end
            if (last_sample) begin
              s_ready_q <= 1'b0;
              state_q   <= DONE;
            end
          end
        end

`ifdef CAPTURE_RING_MODE_EN
        FLUSH: begin
          if (pk_half) begin
            write_q <= 1'b1;
            addr_q  <= ptr_q;
            be_q    <= pk_be;
            wdata_q <= pk_word;
            ptr_q   <= ptr_d;
            words_q <= words_q + 1'b1;
            if (wrap_hit) wrapped_q <= 1'b1;
          end
          state_q <= DONE;
        end
`endif

        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef CAPTURE_RING_MODE_EN
  // Only consumed by the ring-mode build.
  logic unused_wrap;
  assign unused_wrap = wrap_hit;
`endif

  assign s_ready        = s_ready_q;
  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_chipselect = write_q;
  assign mem_write      = write_q;
  assign mem_writedata  = wdata_q;
  assign mem_clken      = clken_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign words_written  = words_q;

endmodule
